iiitb_rtc_set_ctrl: RTL

//  Time-keeping and time-set controller for the RTC. Holds BCD hh:mm:ss and an alarm hh:mm,

---
 rtl/iiitb_rtc_pkg.sv | 30 +++
 rtl/iiitb_bcd2.sv | 38 +++
 rtl/iiitb_rtc_set_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/iiitb_rtc_pkg.sv
// Shared RTC definitions: set-mode state codes, BCD field limits and the BCD increment helper.
package iiitb_rtc_pkg;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_SET_HR  = 3'd1;
    localparam logic [2:0] ST_SET_MIN = 3'd2;
    localparam logic [2:0] ST_SET_SEC = 3'd3;
    localparam logic [2:0] ST_ALM_HR  = 3'd4;
    localparam logic [2:0] ST_ALM_MIN = 3'd5;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // Two-digit BCD increment that wraps to 00 once the field limit is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
        logic [7:0] res;
        if (val == lim)
            res = 8'h00;
        else if (val[3:0] == 4'd9)
            res = {val[7:4] + 4'd1, 4'd0};
        else
            res = {val[7:4], val[3:0] + 4'd1};
        return res;
    endfunction

    function automatic logic [2:0] next_field(input logic [2:0] st);
        return (st == ST_ALM_MIN) ? ST_RUN : st + 3'd1;
    endfunction

endpackage

// File: rtl/iiitb_bcd2.sv
// Two-digit BCD register with increment/clear; wrap flags the increment that rolls it to 00.
module iiitb_bcd2
    import iiitb_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] max,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       wrap
);

    logic [7:0] val_q, val_d;

    // NOTE: val_d gets a default first so no path through this block can infer a latch.
    always_comb begin
        val_d = val_q;
        if (clr)
            val_d = 8'h00;
        else if (inc)
            val_d = bcd_inc(val_q, max);
    end

    // NOTE: sequential state uses non-blocking assignments with a synchronous reset.
    always_ff @(posedge clk) begin
        if (rst)
            val_q <= 8'h00;
        else
            val_q <= val_d;
    end

    assign tens  = val_q[7:4];
    assign units = val_q[3:0];
    assign wrap  = inc && !clr && (val_q == max);

endmodule

// File: rtl/iiitb_rtc_set_ctrl.sv
// RTC time-keeping / time-set controller: BCD time and alarm registers, set-mode FSM,
// idle auto-exit timer and timed alarm output.
module iiitb_rtc_set_ctrl
    import iiitb_rtc_pkg::*;
#(
    parameter int ALARM_SECS = 60,
    parameter int AUTO_EXIT  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       alarm_en,
    output logic [3:0] hrm,
    output logic [3:0] hrl,
    output logic [3:0] minm,
    output logic [3:0] minl,
    output logic [3:0] secm,
    output logic [3:0] secl,
    output logic [3:0] alm_hrm,
    output logic [3:0] alm_hrl,
    output logic [3:0] alm_minm,
    output logic [3:0] alm_minl,
    output logic [2:0] field_sel,
    output logic       alarm_fire
);

    localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);
    localparam logic [7:0] IDLE_LIM  = 8'(AUTO_EXIT);

    logic [2:0] state_q, state_d;
    logic [7:0] idle_q, idle_d;
    logic [7:0] alm_cnt_q, alm_cnt_d;
    logic       fire_q, fire_d;

    logic       in_run, run_tick, inc_p, any_btn;
    logic       sec_wrap, min_wrap, hr_wrap, alm_hr_wrap, alm_min_wrap;
    logic       sec_clr, min_inc, hr_inc;
    logic [7:0] next_min, next_hr;
    logic       alarm_hit;

    assign in_run   = (state_q == ST_RUN);
    assign run_tick = in_run && tick;
    assign inc_p    = btn_inc && !btn_mode;
    assign any_btn  = btn_mode || btn_inc;

    // In RUN the wrap outputs chain the carry; in set states only btn_inc touches a field.
    assign sec_clr = (state_q == ST_SET_SEC) && inc_p;
    assign min_inc = in_run ? sec_wrap : ((state_q == ST_SET_MIN) && inc_p);
    assign hr_inc  = in_run ? min_wrap : ((state_q == ST_SET_HR) && inc_p);

    iiitb_bcd2 u_sec (.clk(clk), .rst(rst), .inc(run_tick), .clr(sec_clr), .max(MS_MAX),
                      .tens(secm), .units(secl), .wrap(sec_wrap));
    iiitb_bcd2 u_min (.clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0), .max(MS_MAX),
                      .tens(minm), .units(minl), .wrap(min_wrap));
    iiitb_bcd2 u_hr  (.clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0), .max(HR_MAX),
                      .tens(hrm), .units(hrl), .wrap(hr_wrap));
    iiitb_bcd2 u_alm_hr  (.clk(clk), .rst(rst), .inc((state_q == ST_ALM_HR) && inc_p),
                          .clr(1'b0), .max(HR_MAX),
                          .tens(alm_hrm), .units(alm_hrl), .wrap(alm_hr_wrap));
    iiitb_bcd2 u_alm_min (.clk(clk), .rst(rst), .inc((state_q == ST_ALM_MIN) && inc_p),
                          .clr(1'b0), .max(MS_MAX),
                          .tens(alm_minm), .units(alm_minl), .wrap(alm_min_wrap));

    // Day rollover and alarm-field wraps need no further action.
    logic unused_wraps;
    assign unused_wraps = hr_wrap ^ alm_hr_wrap ^ alm_min_wrap;

    // The new time can only read hh:mm:00 when seconds wrap, so compare the post-tick hh:mm.
    assign next_min  = bcd_inc({minm, minl}, MS_MAX);
    assign next_hr   = min_wrap ? bcd_inc({hrm, hrl}, HR_MAX) : {hrm, hrl};
    assign alarm_hit = sec_wrap && alarm_en &&
                       ({next_hr, next_min} == {alm_hrm, alm_hrl, alm_minm, alm_minl});

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        if (btn_mode) begin
            state_d = next_field(state_q);
            idle_d  = 8'd0;
        end else if (!in_run) begin
            if (btn_inc)
                idle_d = 8'd0;
            else if (tick) begin
                if (idle_q + 8'd1 == IDLE_LIM) begin
                    state_d = ST_RUN;
                    idle_d  = 8'd0;
                end else
                    idle_d = idle_q + 8'd1;
            end
        end
    end

    always_comb begin
        fire_d    = fire_q;
        alm_cnt_d = alm_cnt_q;
        if (alarm_hit) begin
            fire_d    = 1'b1;
            alm_cnt_d = 8'd0;
        end else if (fire_q) begin
            if (any_btn || !alarm_en) begin
                fire_d    = 1'b0;
                alm_cnt_d = 8'd0;
            end else if (tick) begin
                if (alm_cnt_q + 8'd1 == ALARM_LIM) begin
                    fire_d    = 1'b0;
                    alm_cnt_d = 8'd0;
                end else
                    alm_cnt_d = alm_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            idle_q    <= 8'd0;
            alm_cnt_q <= 8'd0;
            fire_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            alm_cnt_q <= alm_cnt_d;
            fire_q    <= fire_d;
        end
    end

    assign field_sel  = state_q;
    assign alarm_fire = fire_q;

endmodule
